// File: rtl/sum_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sum_uart_pkg
//  Description : Shared types and constants for the adder-sum UART
//                transmitter. Optional parity framing is selected by the
//                macro SUM_UART_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package sum_uart_pkg;

    // Transmitter FSM states; PARITY is only reachable in parity builds.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } sum_uart_state_e;

`ifdef SUM_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Level of the serial line between frames (mark).
    localparam logic c_IDLE_LEVEL = 1'b1;

    // Even parity bit: XOR of all data bits.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sum_uart_baud.sv
`default_nettype none
// ============================================================================
//  Module      : sum_uart_baud
//  Description : Baud divider for the sum UART. Counts CLK_DIV clocks per
//                bit while a frame runs and flags the last cycle of each bit
//                with a single-cycle bit_tick. Restarted on every frame load.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_uart_baud #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic bit_tick
);

    localparam int               CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_div_cnt;

    // Baud counter: held at zero when idle or on frame load, wraps each bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (restart || !run) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == c_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // The tick must not depend on restart: the load decision itself uses it.
    assign bit_tick = run && (r_div_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/sum_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sum_uart_tx
//  Description : Serialises the 8-bit adder result as a UART frame (8N1,
//                LSB first) behind a one-entry valid/ready holding buffer.
//                Define SUM_UART_PARITY_EN to insert an even parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    sum_uart_state_e r_state, w_state_nxt;
    logic            r_buf_full, w_buf_full_nxt;
    logic [7:0]      r_buf_data;
    logic [7:0]      r_shift, w_shift_nxt;
    logic [2:0]      r_bit_idx, w_bit_idx_nxt;
    logic            r_tx, w_tx_nxt;
    logic            r_busy;
    logic            r_ready;
    logic            w_accept;
    logic            w_load;
    logic            w_bit_tick;
    logic            w_run;
`ifdef SUM_UART_PARITY_EN
    logic            r_parity, w_parity_nxt;
`endif

    assign w_accept = in_valid && r_ready;
    assign w_run    = (r_state != IDLE);

    sum_uart_baud #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (w_load),
        .run      (w_run),
        .bit_tick (w_bit_tick)
    );

    // Next-state logic for the FSM, shifter, buffer and line level.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_load        = 1'b0;
`ifdef SUM_UART_PARITY_EN
        w_parity_nxt  = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (r_buf_full) w_load = 1'b1;
            end
            START: begin
                if (w_bit_tick) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = 3'd0;
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef SUM_UART_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef SUM_UART_PARITY_EN
            PARITY: begin
                if (w_bit_tick) w_state_nxt = STOP;
            end
`endif
            STOP: begin
                // Chain straight into the next frame when a byte is waiting.
                if (w_bit_tick) begin
                    if (r_buf_full) w_load = 1'b1;
                    else            w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_load) begin
            w_state_nxt = START;
            w_shift_nxt = r_buf_data;
`ifdef SUM_UART_PARITY_EN
            w_parity_nxt = even_parity(r_buf_data);
`endif
        end

        // Load only happens when full and accept only when empty: exclusive.
        if (w_load)        w_buf_full_nxt = 1'b0;
        else if (w_accept) w_buf_full_nxt = 1'b1;
        else               w_buf_full_nxt = r_buf_full;

        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef SUM_UART_PARITY_EN
            PARITY:  w_tx_nxt = w_parity_nxt;
`endif
            default: w_tx_nxt = c_IDLE_LEVEL;
        endcase
    end

    // State registers; outputs are registered so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_buf_full <= 1'b0;
            r_buf_data <= 8'h00;
            r_shift    <= 8'h00;
            r_bit_idx  <= 3'd0;
            r_tx       <= c_IDLE_LEVEL;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
`ifdef SUM_UART_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_buf_full <= w_buf_full_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != IDLE) || w_buf_full_nxt;
            r_ready    <= !w_buf_full_nxt;
`ifdef SUM_UART_PARITY_EN
            r_parity   <= w_parity_nxt;
`endif
            if (w_accept) r_buf_data <= in_data;
        end
    end

    assign in_ready = r_ready;
    assign tx       = r_tx;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sum_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_uart_tx
//  Description : Directed self-checking bench for sum_uart_tx with CLK_DIV=4,
//                including the adder front end (ui_in + uio_in) and the
//                uo_out[0] routing. Honours SUM_UART_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_uart_tx;
    import sum_uart_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int FLEN    = FRAME_BITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_data_drv = 8'h00;
    logic       in_valid = 1'b0;
    logic       use_adder = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] dut_data;
    wire        in_ready;
    wire        tx;
    wire        busy;
    wire  [7:0] uo_out;

    int total = 0;
    int bad   = 0;

    assign dut_data = use_adder ? (ui_in + uio_in) : in_data_drv;
    assign uo_out   = {7'b0000000, tx};

    sum_uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (dut_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit index i.
    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0)      return 1'b0;
        else if (i <= 8) return d[i-1];
`ifdef SUM_UART_PARITY_EN
        else if (i == 9) return ^d;
`endif
        else             return 1'b1;
    endfunction

    // Called at the negedge of START cycle 0; returns at the negedge after the frame.
    task automatic check_frame(input logic [7:0] d, input string tag);
        for (int c = 0; c < FLEN; c++) begin
            if (c != 0) @(negedge clk);
            chk($sformatf("%s_tx_c%0d", tag, c), uo_out[0], frame_bit(d, c / CLK_DIV));
            chk($sformatf("%s_busy_c%0d", tag, c), busy, 1'b1);
        end
        @(negedge clk);
    endtask

    // Called at a negedge; byte is accepted on the next posedge.
    task automatic send(input logic [7:0] d);
        in_data_drv = d;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
    endtask

    initial begin
        // Reset takes effect without any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_tx", tx, 1'b1);

        // Single byte 0xA5.
        send(8'hA5);
        chk("a5_ready_low", in_ready, 1'b0);
        chk("a5_busy_accept", busy, 1'b1);
        chk("a5_tx_pre", tx, 1'b1);
        @(negedge clk);
        chk("a5_ready_back", in_ready, 1'b1);
        check_frame(8'hA5, "a5");
        chk("a5_busy_end", busy, 1'b0);
        chk("a5_tx_end", tx, 1'b1);

        // Back-to-back 0x3C, 0xFF with in_valid held; later data ignored.
        in_data_drv = 8'h3C;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data_drv = 8'hFF;
        chk("b2b_ready_full", in_ready, 1'b0);
        @(negedge clk);
        chk("b2b_ready_drain", in_ready, 1'b1);
        fork
            begin
                check_frame(8'h3C, "f3c");
                check_frame(8'hFF, "fff");
            end
            begin
                @(posedge clk);
                #1 in_data_drv = 8'h55;
                for (int k = 0; k < 15; k++) begin
                    @(negedge clk);
                    chk($sformatf("held_ready_%0d", k), in_ready, 1'b0);
                    in_data_drv = (k[0]) ? 8'h55 : 8'h66;
                end
                in_valid = 1'b0;
            end
        join
        chk("b2b_busy_end", busy, 1'b0);
        chk("b2b_tx_end", tx, 1'b1);
        chk("b2b_ready_end", in_ready, 1'b1);

        // Reset mid-DATA of 0x81 with 0x42 buffered.
        send(8'h81);
        @(negedge clk);
        send(8'h42);
        chk("rst_buffered", in_ready, 1'b0);
        repeat (8) @(negedge clk);
        chk("rst_mid_data_tx", tx, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_ready", in_ready, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2 * FLEN; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_tx_%0d", k), tx, 1'b1);
            chk($sformatf("post_rst_busy_%0d", k), busy, 1'b0);
        end

        // Parity coverage: 0xA5 (even parity 0) then 0x01 (parity 1).
        send(8'hA5);
        @(negedge clk);
        check_frame(8'hA5, "pa5");
        chk("pa5_busy_end", busy, 1'b0);
        send(8'h01);
        @(negedge clk);
        check_frame(8'h01, "p01");
        chk("p01_busy_end", busy, 1'b0);

        // Adder front end: 0x12 + 0x34 = 0x46 out on uo_out[0].
        use_adder = 1'b1;
        ui_in     = 8'h12;
        uio_in    = 8'h34;
        send(8'h00);
        @(negedge clk);
        check_frame(8'h46, "sum46");
        chk("sum46_busy_end", busy, 1'b0);
        chk("sum46_line_idle", uo_out[0], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sum_uart_tx.md
Name: sum_uart_tx

Overview:
- Downstream consumer of the top-level 8-bit adder result (ui_in + uio_in).
- Accepts a byte over a valid/ready handshake into a one-entry holding buffer.
- Serializes each byte as an 8N1 UART frame, LSB first, on a single pin. The top level routes that pin to uo_out[0].
- Lets the adder result leave the chip serially, freeing the remaining output pins.

Parameters:
- CLK_DIV, 16: clk cycles per UART bit. Legal range is 2..65535. Bit counter width is $clog2(CLK_DIV).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  8  byte to transmit (adder sum)
- in_valid  input  1  in_data valid this cycle
- in_ready  output  1  holding buffer empty; the byte is taken on a clk edge with in_valid&&in_ready
- tx  output  1  serial line, idle high
- busy  output  1  a frame is in progress or the buffer is full

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - On reset assertion, with no clock needed: tx=1, busy=0, in_ready=1, buffer cleared, FSM=IDLE, counters=0.
  - Reset mid-frame aborts the frame immediately; tx returns high and any buffered byte is lost.
- Handshake:
  - in_ready = !buf_full, driven from a register only, with no combinational path from in_valid.
  - A byte is accepted on an edge where in_valid && in_ready; buf_full sets on that edge.
  - in_data is sampled only on accept. in_valid without in_ready has no effect.
- FSM states: IDLE, START, DATA, STOP. Each of START, DATA-bit and STOP lasts exactly CLK_DIV cycles, tracked by baud counter div_cnt (0..CLK_DIV-1).
- IDLE:
  - tx=1.
  - If buf_full: load shift register from the buffer, clear buf_full, and go to START on the same edge.
- START: tx=0. After CLK_DIV cycles, go to DATA with bit_idx=0.
- DATA:
  - tx = shift[0]. The shift register shifts right once per bit.
  - After 8 bits, go to STOP.
- STOP:
  - tx=1 for CLK_DIV cycles.
  - On the last STOP cycle: if buf_full, load the buffer and go straight to START (gap-free back-to-back frames). Otherwise go to IDLE.
- Latency:
  - A byte accepted at edge N, with the FSM idle, enters START at edge N+1; tx=0 is visible after edge N+1.
  - Frame length is 10*CLK_DIV cycles.
- Simultaneous events:
  - The buffer drains on the same edge that the FSM loads it. in_ready rises the following cycle, so accept and drain never occur on the same edge.
  - A new byte may be accepted at any time while a frame shifts; this is the one-byte buffering.
- busy = (state != IDLE) || buf_full, registered so it is consistent with the state.
- No width growth: the byte is transmitted as-is; the adder's carry is not represented.

Optional Feature:
- Macro: SUM_UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLK_DIV cycles.
  - tx = even parity (XOR of the 8 data bits, latched at load).
  - Frame length becomes 11*CLK_DIV cycles.
- Undefined: no PARITY state or logic; 8N1 framing as above.

Decomposition:
- Package sum_uart_pkg contains:
  - the state enum typedef (IDLE/START/DATA/PARITY/STOP, 3-bit);
  - localparam FRAME_BITS (10, or 11 with parity);
  - the idle line level constant.
- One natural sub-module: sum_uart_baud, the CLK_DIV counter that emits a single-cycle bit_tick and is restarted on frame load.
- FSM, shift register and holding buffer stay in sum_uart_tx.

Test Plan:
- CLK_DIV=4, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy high for 40 cycles then low; in_ready back to 1 one cycle after accept.
- Send 0x3C then 0xFF back-to-back, with in_valid held -> 0xFF is accepted during the 0x3C frame; the STOP of 0x3C is followed immediately by START of 0xFF with no idle cycle; total of 80 cycles busy.
- in_valid held high while buf_full during a frame -> in_ready=0; in_data changes are ignored; only the accepted bytes appear on tx.
- Assert rst_n=0 mid-DATA of 0x81 with a second byte buffered -> tx=1 and in_ready=1 asynchronously; after release, tx stays 1 with no residual frame.
- With SUM_UART_PARITY_EN, send 0xA5 then 0x01 -> parity bits are 0 and 1 respectively; each frame lasts 44 cycles with CLK_DIV=4.
- Top-level integration, ui_in=0x12, uio_in=0x34, in_valid pulse -> a serial byte of 0x46 is observed on uo_out[0].
